// File: rtl/pulse_train_generator.sv
// pulse_train_generator: emits exactly n_reg rising edges per window of
// GATE_CYCLES clocks. A Bresenham-style accumulator adds 2*n_reg per clock
// and toggles pulse_out on every wrap past GATE_CYCLES, so the 2*n_reg
// toggles are spread as evenly as the clock allows. The requested N is
// captured only at window boundaries, so each window's count is exact.
module pulse_train_generator #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 10,
  parameter int ACC_W       = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] N,
  output logic       pulse_out,
  output logic       win_start,
  output logic       busy,
  output logic [7:0] n_active
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GATE_CYCLES - 1);
  localparam logic [ACC_W-1:0] GATE_ACC = ACC_W'(GATE_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       n_reg_q, n_reg_d;
  logic             pulse_q, pulse_d;
  logic             win_start_q, win_start_d;
  logic [ACC_W-1:0] sum;

  // Next-state logic: window sequencing, accumulator step and N capture.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    n_reg_d     = n_reg_q;
    pulse_d     = pulse_q;
    win_start_d = 1'b0;
    // ACC_W is sized so acc (< GATE_CYCLES) plus 2*255 never overflows.
    sum         = acc_q + ACC_W'({n_reg_q, 1'b0});

    case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        if (en) begin
          state_d     = RUN;
          n_reg_d     = N;
          win_cnt_d   = '0;
          acc_d       = '0;
          win_start_d = 1'b1;
        end
      end

      RUN: begin
        if (sum >= GATE_ACC) begin
          acc_d   = sum - GATE_ACC;
          pulse_d = ~pulse_q;
        end else begin
          acc_d = sum;
        end

        if (win_cnt_q == LAST_CNT) begin
          // The last accumulation of a window always returns acc to 0 and
          // pulse_out low, so the next window can start with no gap cycle.
          win_cnt_d = '0;
          if (en) begin
            n_reg_d     = N;
            win_start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any window in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      n_reg_q     <= '0;
      pulse_q     <= 1'b0;
      win_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      n_reg_q     <= n_reg_d;
      pulse_q     <= pulse_d;
      win_start_q <= win_start_d;
    end
  end

  assign pulse_out = pulse_q;
  assign win_start = win_start_q;
  assign busy      = (state_q == RUN);
  assign n_active  = n_reg_q;

endmodule
